alu_share_arbiter: RTL and testbench

- Sequences the single shared ALU between two requesters: requester 0 is the execute stage, requester 1 is the branch/address helper.
- Performs round-robin arbitration and accepts one operation at a time with a valid/ready handshake.
- Drives registered operands and aluc into the external alu instance, then captures r and all four flags into a held response.
- Sits between the CPU31 control path and the alu module.

---
 rtl/alu_share_arbiter.sv | 106 ++++++++++
 tb/tb_alu_share_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer for the single shared ALU: accepts one op from the
// execute stage or the branch/address helper, runs it, and holds the response.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_aluc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_aluc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_aluc,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic [CNTW-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   grant;
    logic   take;

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        take       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_valid && req1_valid) grant = prio;
                else grant = req1_valid;
                // No handshake may complete while reset is being applied
                take       = rst_n && (req0_valid || req1_valid);
                req0_ready = take && !grant;
                req1_ready = take && grant;
                if (take) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_aluc  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_flags <= '0;
            ops_done  <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                alu_a    <= grant ? req1_a : req0_a;
                alu_b    <= grant ? req1_b : req0_b;
                alu_aluc <= grant ? req1_aluc : req0_aluc;
                rsp_id   <= grant;
            end
            if (state == EXEC) begin
                rsp_r     <= alu_r;
                rsp_flags <= {alu_zero, alu_carry, alu_negative, alu_overflow};
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                prio      <= ~rsp_id;
                if (ops_done != '1) ops_done <= ops_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU drives the alu side and a
// transaction-level model predicts handshakes, responses and counters.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_aluc;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_aluc;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_aluc;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_r;
    logic [3:0]  rsp_flags;
    logic [15:0] ops_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_flags(rsp_flags),
        .busy(busy), .ops_done(ops_done)
    );

    // Returns {r, zero, carry, negative, overflow}
    function automatic logic [35:0] alu_f(
        input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            4'b0000, 4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0001, 4'b0011: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            default: r = b << a[4:0];
        endcase
        return {r, (r == 32'd0), c, r[31], v};
    endfunction

    assign {alu_r, alu_zero, alu_carry, alu_negative, alu_overflow} =
        alu_f(alu_a, alu_b, alu_aluc);

    // Transaction-level model
    bit          m_busy, m_exec, m_rsp, m_prio, m_id;
    logic [31:0] m_a, m_b, m_r;
    logic [3:0]  m_op, m_fl;
    logic [15:0] m_ops;
    int          grants[$];

    task automatic model_reset();
        m_busy = 0; m_exec = 0; m_rsp = 0; m_prio = 0; m_id = 0;
        m_a = '0; m_b = '0; m_op = '0; m_r = '0; m_fl = '0; m_ops = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with inputs already driven
    task automatic cycle();
        logic g, take;
        #2;
        take = rst_n && !m_busy && (req0_valid || req1_valid);
        g = (req0_valid && req1_valid) ? m_prio : req1_valid;
        chk("req0_ready", req0_ready, take && !g);
        chk("req1_ready", req1_ready, take && g);
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_r", rsp_r, m_r);
        chk("rsp_flags", rsp_flags, m_fl);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_aluc", alu_aluc, m_op);
        chk("ops_done", ops_done, m_ops);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (take) begin
            m_busy = 1;
            m_exec = 1;
            m_id = g;
            m_a = g ? req1_a : req0_a;
            m_b = g ? req1_b : req0_b;
            m_op = g ? req1_aluc : req0_aluc;
            grants.push_back(int'(g));
        end else if (m_exec) begin
            m_exec = 0;
            m_rsp = 1;
            {m_r, m_fl} = alu_f(m_a, m_b, m_op);
        end else if (m_rsp && rsp_ready) begin
            m_rsp = 0;
            m_busy = 0;
            m_prio = ~m_id;
            if (m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] hold_r;
        logic [3:0]  hold_fl;
        logic        hold_id;
        int          n;

        rst_n = 0;
        rsp_ready = 0;
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_aluc = 4'd0;
        req1_valid = 1; req1_a = 32'd5; req1_b = 32'd6; req1_aluc = 4'd0;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        chk("reset_ops_done", ops_done, 16'd0);
        chk("reset_busy", busy, 1'b0);

        // Single ADDU from requester 0
        rst_n = 1;
        req1_valid = 0;
        rsp_ready = 1;
        req0_valid = 1; req0_a = 32'd3; req0_b = 32'd4; req0_aluc = 4'b0000;
        cycle();
        req0_valid = 0;
        cycle();
        chk("single_valid", rsp_valid, 1'b1);
        chk("single_r", rsp_r, 32'd7);
        chk("single_flags", rsp_flags, 4'b0000);
        chk("single_id", rsp_id, 1'b0);
        cycle();
        chk("single_ops", ops_done, 16'd1);

        // SUB from requester 1 going negative
        req1_valid = 1; req1_a = 32'd3; req1_b = 32'd4; req1_aluc = 4'b0011;
        cycle();
        req1_valid = 0;
        cycle();
        chk("sub_r", rsp_r, 32'hFFFF_FFFF);
        chk("sub_negative", rsp_flags[1], 1'b1);
        chk("sub_zero", rsp_flags[3], 1'b0);
        chk("sub_id", rsp_id, 1'b1);
        cycle();

        // Continuous contention
        grants.delete();
        req0_valid = 1;
        req1_valid = 1;
        for (int i = 0; i < 40 && grants.size() < 4; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_aluc = 4'($urandom_range(0, 7));
            req1_a = $urandom; req1_b = $urandom; req1_aluc = 4'($urandom_range(0, 7));
            cycle();
        end
        req0_valid = 0;
        req1_valid = 0;
        cycle();
        cycle();
        chk("contention_count", grants.size(), 4);
        n = grants.size();
        for (int i = 0; i < 4 && i < n; i++)
            chk("contention_order", grants[i], i % 2);
        chk("contention_ops", ops_done, 16'd6);

        // Backpressure with both requesters waiting
        grants.delete();
        rsp_ready = 0;
        req0_valid = 1;
        req1_valid = 1;
        req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_aluc = 4'b0010;
        req1_a = 32'd9; req1_b = 32'd9; req1_aluc = 4'b0001;
        cycle();
        cycle();
        hold_r = 32'h0000_0000;
        hold_fl = 4'b1101;
        hold_id = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_r", rsp_r, hold_r);
            chk("bp_flags", rsp_flags, hold_fl);
            chk("bp_id", rsp_id, hold_id);
            chk("bp_busy", busy, 1'b1);
        end
        rsp_ready = 1;
        cycle();
        cycle();
        chk("bp_next_grants", grants.size(), 2);
        if (grants.size() == 2)
            chk("bp_next_id", grants[1], 1);
        req0_valid = 0;
        req1_valid = 0;
        cycle();
        cycle();

        // Reset during EXEC
        req0_valid = 1; req0_a = 32'd11; req0_b = 32'd22; req0_aluc = 4'b0000;
        cycle();
        req0_valid = 0;
        rst_n = 0;
        cycle();
        rst_n = 1;
        #2;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", rsp_valid, 1'b0);
        chk("midrst_ops", ops_done, 16'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = $urandom; req0_b = $urandom; req0_aluc = 4'($urandom);
            req1_a = $urandom; req1_b = $urandom; req1_aluc = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                req0_b = req0_a;
                req0_aluc = 4'b0011;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
